// File: rtl/rst_lut_rr_arbiter_8bit_if.sv
// Bus bundle for rst_lut_rr_arbiter_8bit: request/data inputs and grant/data outputs.
// master: the requester side; slave: the arbiter.
interface rst_lut_rr_arbiter_8bit_if #(
   parameter int NUM_REQ = 8
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] din;
   logic [NUM_REQ-1:0] gnt;
   logic               q;
   logic [NUM_REQ-1:0] out;
   logic               busy;

   modport master (
      output req, din,
      input  gnt, q, out, busy
   );

   modport slave (
      input  req, din,
      output gnt, q, out, busy
   );
endinterface

// File: rtl/rst_lut_rr_arbiter_8bit.sv
// Round-robin arbiter sharing one registered data bit q among NUM_REQ requesters.
// Each grant lasts at most HOLD_CYCLES cycles, followed by a GAP cycle and an IDLE
// cycle with no owner. All registers reset asynchronously on rst (active-high); the
// gated outputs out[i] = din[i] & gnt[i] are also forced low while rst is high.
// Optional build macro RST_LUT_ARB_FIXED_PRIO_EN: ignore the rotating pointer so the
// lowest requesting index always wins (hold and gap timing unchanged).
module rst_lut_rr_arbiter_8bit #(
   parameter int NUM_REQ     = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   rst_lut_rr_arbiter_8bit_if.slave        arb
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               q_q, q_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   search_base;
   logic [IDX_W-1:0]   idx_k;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic               hold_done;
   logic               release_now;

   // Index (base + k) modulo NUM_REQ, so non-power-of-two sizes also wrap correctly.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NUM_REQ;
      return IDX_W'(s);
   endfunction

`ifdef RST_LUT_ARB_FIXED_PRIO_EN
   // Fixed priority: the search always starts from requester 0.
   assign search_base = '0;
`else
   // Round robin: the search starts just after the previous owner.
   assign search_base = ptr_q;
`endif

   // Winner search: first active request at base, base+1, ... wrapping around.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      idx_k   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_k = wrap_idx(search_base, k);
         if (!win_vld && arb.req[idx_k]) begin
            win_vld = 1'b1;
            win_idx = idx_k;
         end
      end
   end

   // A requester dropping on the hold-limit edge is still a single release.
   assign hold_done   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
   assign release_now = !arb.req[owner_q] || hold_done;

   // State register: every register clears asynchronously on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         q_q     <= 1'b0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: grant selection in IDLE, hold counting in GRANT, one-cycle GAP.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      q_d     = q_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = GRANT;
               gnt_d   = NUM_REQ'(1) << win_idx;
               owner_d = win_idx;
               cnt_d   = '0;
            end else begin
               gnt_d = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d = GAP;
               gnt_d   = '0;
               q_d     = 1'b0;
               ptr_d   = wrap_idx(owner_q, 1);
            end else begin
               q_d   = arb.din[owner_q];
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
            gnt_d   = '0;
            q_d     = 1'b0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Output logic: registered grant/data/busy, and reset-gated per-channel data.
   always_comb begin
      arb.gnt  = gnt_q;
      arb.q    = q_q;
      arb.busy = busy_q;
      arb.out  = arb.din & gnt_q & ~{NUM_REQ{rst}};
   end

endmodule
